operand_fetch_stage: RTL and testbench

- Upstream neighbour of the SIMD ALU in the multimedia pipeline.
- Holds the 32 x 128-bit register file with three read ports and one write port.
- Resolves RAW hazards by forwarding from the EX and WB stages, injects immediates into the rs2 operand, and registers the operands plus the 8-bit ALU ctrl into the ID/EX pipeline register.
- Uses a valid/ready handshake on both sides.

---
 rtl/operand_fetch_stage.sv | 139 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 32-entry register file, EX/WB forwarding, immediate
// injection into rs2, and the ID/EX pipeline register with valid/ready handshake.
module operand_fetch_stage #(
  parameter int unsigned REG_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned IMM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rs3,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_use_imm,
  input  logic [IMM_WIDTH-1:0]  id_imm,
  input  logic [REG_WIDTH-1:0]  alu_result,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0]  wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic [REG_WIDTH-1:0]  ex_rs1,
  output logic [REG_WIDTH-1:0]  ex_rs2,
  output logic [REG_WIDTH-1:0]  ex_rs3,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_wr_en
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  logic [REG_WIDTH-1:0]  rf_q [NUM_REGS];
  logic [REG_WIDTH-1:0]  rf_d [NUM_REGS];

  logic                  ex_valid_q, ex_valid_d;
  logic [CTRL_WIDTH-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [REG_WIDTH-1:0]  ex_rs1_q,   ex_rs1_d;
  logic [REG_WIDTH-1:0]  ex_rs2_q,   ex_rs2_d;
  logic [REG_WIDTH-1:0]  ex_rs3_q,   ex_rs3_d;
  logic [ADDR_WIDTH-1:0] ex_rd_q,    ex_rd_d;
  logic                  ex_wr_en_q, ex_wr_en_d;

  logic                  accept;
  logic                  retire;
  logic                  ex_fwd;
  logic [REG_WIDTH-1:0]  op1, op2, op3;

  assign id_ready = !ex_valid_q || ex_ready;
  assign accept   = id_valid && id_ready;
  assign retire   = ex_valid_q && ex_ready;
  // EX result is only forwardable when that instruction leaves EX this cycle.
  assign ex_fwd   = retire && ex_wr_en_q;

  function automatic logic [REG_WIDTH-1:0] resolve(input logic [ADDR_WIDTH-1:0] rs);
    if (ex_fwd && (ex_rd_q == rs)) begin
      return alu_result;
    end else if (wb_en && (wb_addr == rs)) begin
      return wb_data;
    end else begin
      return rf_q[rs];
    end
  endfunction

  always_comb begin
    op1 = resolve(id_rs1);
    op3 = resolve(id_rs3);
    if (id_use_imm) begin
      op2 = {{(REG_WIDTH-IMM_WIDTH){1'b0}}, id_imm};
    end else begin
      op2 = resolve(id_rs2);
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en) begin
      rf_d[wb_addr] = wb_data;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rs3_d   = ex_rs3_q;
    ex_rd_d    = ex_rd_q;
    ex_wr_en_d = ex_wr_en_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rs1_d   = op1;
      ex_rs2_d   = op2;
      ex_rs3_d   = op3;
      ex_rd_d    = id_rd;
      ex_wr_en_d = id_wr_en;
    end else if (retire) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rs3_q   <= '0;
      ex_rd_q    <= '0;
      ex_wr_en_q <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rs3_q   <= ex_rs3_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_en_q <= ex_wr_en_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;
  assign ex_rs3   = ex_rs3_q;
  assign ex_rd    = ex_rd_q;
  assign ex_wr_en = ex_wr_en_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage: reset, bypassing,
// EX-over-WB priority, immediates, stall hold and reset mid-stream.
module tb_operand_fetch_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid;
  logic         id_ready;
  logic [7:0]   id_ctrl;
  logic [4:0]   id_rs1, id_rs2, id_rs3, id_rd;
  logic         id_wr_en;
  logic         id_use_imm;
  logic [15:0]  id_imm;
  logic [127:0] alu_result;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [127:0] wb_data;
  logic         ex_valid;
  logic         ex_ready;
  logic [7:0]   ex_ctrl;
  logic [127:0] ex_rs1, ex_rs2, ex_rs3;
  logic [4:0]   ex_rd;
  logic         ex_wr_en;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [127:0] V1111 = {8{16'h1111}};
  localparam logic [127:0] VA5   = {16{8'hA5}};
  localparam logic [127:0] VDEAD = 128'hDEAD;
  localparam logic [127:0] VBEEF = 128'hBEEF;
  localparam logic [127:0] V7777 = {8{16'h7777}};
  localparam logic [127:0] V9999 = {8{16'h9999}};
  localparam logic [127:0] V5555 = {8{16'h5555}};

  always #5 clk = ~clk;

  operand_fetch_stage #(
    .REG_WIDTH (128),
    .ADDR_WIDTH(5),
    .CTRL_WIDTH(8),
    .IMM_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_ctrl   (id_ctrl),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rs3    (id_rs3),
    .id_rd     (id_rd),
    .id_wr_en  (id_wr_en),
    .id_use_imm(id_use_imm),
    .id_imm    (id_imm),
    .alu_result(alu_result),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_ctrl   (ex_ctrl),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_rs3    (ex_rs3),
    .ex_rd     (ex_rd),
    .ex_wr_en  (ex_wr_en)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rs3, input logic [4:0] rd, input logic wr_en,
                       input logic use_imm, input logic [15:0] imm);
    id_valid   = 1'b1;
    id_ctrl    = ctrl;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rs3     = rs3;
    id_rd      = rd;
    id_wr_en   = wr_en;
    id_use_imm = use_imm;
    id_imm     = imm;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [127:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rs3 = '0;
    id_rd = '0; id_wr_en = 1'b0; id_use_imm = 1'b0; id_imm = '0; alu_result = '0;
    ex_ready = 1'b1;
    wb(1'b1, 5'd9, V9999);
    issue(8'hFF, 5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 16'h0);
    step(); step();
    rst = 1'b0; id_valid = 1'b0; wb(1'b0, '0, '0);
    #1;
    check("rst_ex_valid", {127'b0, ex_valid}, 128'd0);
    check("rst_ex_ctrl",  {120'b0, ex_ctrl}, 128'd0);
    check("rst_ex_rs1",   ex_rs1, 128'd0);
    check("rst_id_ready", {127'b0, id_ready}, 128'd1);

    // Write R3, then read it next cycle through the RF.
    wb(1'b1, 5'd3, V1111);
    step();
    wb(1'b0, '0, '0);
    issue(8'h05, 5'd3, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 16'h0);
    step();
    id_valid = 1'b0;
    check("basic_ex_valid", {127'b0, ex_valid}, 128'd1);
    check("basic_ex_rs1",   ex_rs1, V1111);
    check("basic_ex_rs2",   ex_rs2, 128'd0);
    check("basic_ex_rs3",   ex_rs3, 128'd0);
    check("basic_ex_ctrl",  {120'b0, ex_ctrl}, 128'h05);
    check("basic_ex_rd",    {123'b0, ex_rd}, 128'd1);
    check("basic_ex_wr_en", {127'b0, ex_wr_en}, 128'd0);

    // Same-cycle WB bypass on rs1 and rs3; rs2 from RF.
    wb(1'b1, 5'd7, VA5);
    issue(8'h11, 5'd7, 5'd3, 5'd7, 5'd2, 1'b0, 1'b0, 16'h0);
    step();
    wb(1'b0, '0, '0);
    check("byp_ex_rs1", ex_rs1, VA5);
    check("byp_ex_rs2", ex_rs2, V1111);
    check("byp_ex_rs3", ex_rs3, VA5);

    // I1 writes R4; I2 depends on it back-to-back while WB writes R4 too.
    issue(8'h21, 5'd3, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 16'h0);
    step();
    alu_result = VDEAD;
    wb(1'b1, 5'd4, VBEEF);
    issue(8'h22, 5'd4, 5'd4, 5'd5, 5'd4, 1'b0, 1'b0, 16'h0);
    step();
    wb(1'b0, '0, '0);
    alu_result = '0;
    check("fwd_ex_rs2", ex_rs2, VDEAD);
    check("fwd_ex_rs1", ex_rs1, VDEAD);
    check("fwd_ex_rs3", ex_rs3, 128'd0);

    // Immediate overrides rs2 register; R4 now holds the WB value.
    issue(8'h23, 5'd4, 5'd4, 5'd4, 5'd6, 1'b1, 1'b1, 16'h8001);
    step();
    check("imm_ex_rs2", ex_rs2, 128'h8001);
    check("imm_ex_rs1", ex_rs1, VBEEF);
    check("imm_ex_rs3", ex_rs3, VBEEF);

    // Stall three cycles: EX holds, id_ready low, WB still updates RF.
    ex_ready = 1'b0;
    issue(8'h33, 5'd10, 5'd10, 5'd0, 5'd2, 1'b0, 1'b0, 16'h0);
    #1;
    check("stall_id_ready", {127'b0, id_ready}, 128'd0);
    wb(1'b1, 5'd10, V7777);
    for (int k = 0; k < 3; k++) begin
      step();
      wb(1'b0, '0, '0);
      check("stall_ex_valid", {127'b0, ex_valid}, 128'd1);
      check("stall_ex_ctrl",  {120'b0, ex_ctrl}, 128'h23);
      check("stall_ex_rs2",   ex_rs2, 128'h8001);
      check("stall_ex_rs1",   ex_rs1, VBEEF);
      check("stall_id_ready", {127'b0, id_ready}, 128'd0);
    end
    ex_ready = 1'b1;
    #1;
    check("unstall_id_ready", {127'b0, id_ready}, 128'd1);
    step();
    id_valid = 1'b0;
    check("unstall_ex_ctrl", {120'b0, ex_ctrl}, 128'h33);
    check("unstall_ex_rs1",  ex_rs1, V7777);
    check("unstall_ex_rs2",  ex_rs2, V7777);

    // Retire without a new accept empties EX.
    step();
    check("drain_ex_valid", {127'b0, ex_valid}, 128'd0);

    // Reset mid-stream beats a concurrent WB write and an accept.
    wb(1'b1, 5'd9, V9999);
    step();
    wb(1'b0, '0, '0);
    issue(8'h44, 5'd9, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 16'h0);
    step();
    check("pre_rst_ex_rs1", ex_rs1, V9999);
    rst = 1'b1;
    wb(1'b1, 5'd9, V5555);
    issue(8'h55, 5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 16'h0);
    step();
    rst = 1'b0;
    wb(1'b0, '0, '0);
    id_valid = 1'b0;
    check("mid_rst_ex_valid", {127'b0, ex_valid}, 128'd0);
    check("mid_rst_ex_ctrl",  {120'b0, ex_ctrl}, 128'd0);
    check("mid_rst_ex_rs1",   ex_rs1, 128'd0);
    check("mid_rst_ex_rd",    {123'b0, ex_rd}, 128'd0);
    check("mid_rst_ex_wr_en", {127'b0, ex_wr_en}, 128'd0);
    issue(8'h66, 5'd9, 5'd9, 5'd3, 5'd1, 1'b0, 1'b0, 16'h0);
    step();
    id_valid = 1'b0;
    check("mid_rst_r9",  ex_rs1, 128'd0);
    check("mid_rst_r3",  ex_rs3, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
